// File: rtl/opb_reg_pkg.sv
// Shared types and helpers for the OPB register bank: FSM encoding, CTRL bit
// positions and OPB (big-endian bit order) to user (little-endian) conversions.
package opb_reg_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BYTES_W = 4;

  localparam int unsigned CTRL_COMMIT_BIT  = 0;
  localparam int unsigned CTRL_DISCARD_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_GAP  = 2'd2
  } opb_state_e;

  // OPB bit 0 is the MSB: opb[i] lands on user bit 31-i.
  function automatic logic [WORD_W-1:0] opb_to_user32(input logic [0:WORD_W-1] opb);
    logic [WORD_W-1:0] u;
    for (int i = 0; i < int'(WORD_W); i++) u[WORD_W-1-i] = opb[i];
    return u;
  endfunction

  function automatic logic [0:WORD_W-1] user_to_opb32(input logic [WORD_W-1:0] u);
    logic [0:WORD_W-1] o;
    for (int i = 0; i < int'(WORD_W); i++) o[i] = u[WORD_W-1-i];
    return o;
  endfunction

  // OPB_BE[0] covers user byte 3, OPB_BE[3] covers user byte 0.
  function automatic logic [BYTES_W-1:0] opb_to_user_be(input logic [0:BYTES_W-1] be);
    logic [BYTES_W-1:0] u;
    for (int i = 0; i < int'(BYTES_W); i++) u[BYTES_W-1-i] = be[i];
    return u;
  endfunction

  function automatic logic [WORD_W-1:0] be_merge(input logic [WORD_W-1:0]  old_val,
                                                 input logic [WORD_W-1:0]  new_val,
                                                 input logic [BYTES_W-1:0] be);
    logic [WORD_W-1:0] r;
    r = old_val;
    for (int b = 0; b < int'(BYTES_W); b++)
      if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/opb_reg_slot.sv
// One control register: active value, optional shadow with pending flag,
// byte-enable merge and a one-cycle load strobe on every active update.
module opb_reg_slot
  import opb_reg_pkg::*;
#(
  parameter int unsigned C_SHADOW = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en_i,
  input  logic [BYTES_W-1:0]  be_i,
  input  logic [WORD_W-1:0]   wdata_i,
  input  logic                commit_i,
  input  logic                discard_i,
  output logic [WORD_W-1:0]   active_o,
  output logic [WORD_W-1:0]   rdback_o,
  output logic                pending_o,
  output logic                strb_o
);

  logic [WORD_W-1:0] active_q, active_d;
  logic [WORD_W-1:0] shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic              strb_q, strb_d;

  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    strb_d    = 1'b0;
    if (C_SHADOW != 0) begin
      if (wr_en_i) begin
        shadow_d  = be_merge(shadow_q, wdata_i, be_i);
        pending_d = 1'b1;
      end else if (commit_i && pending_q) begin
        active_d  = shadow_q;
        strb_d    = 1'b1;
        pending_d = 1'b0;
      end else if (discard_i && pending_q) begin
        shadow_d  = active_q;
        pending_d = 1'b0;
      end
    end else if (wr_en_i) begin
      // Strobe fires even when no byte is enabled.
      active_d = be_merge(active_q, wdata_i, be_i);
      strb_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      strb_q    <= 1'b0;
    end else begin
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      strb_q    <= strb_d;
    end
  end

  assign active_o  = active_q;
  assign rdback_o  = (C_SHADOW != 0) ? shadow_q : active_q;
  assign pending_o = pending_q;
  assign strb_o    = strb_q;

endmodule

// File: rtl/opb_register_bank.sv
// OPB slave exposing RW control registers, a CTRL word (commit/discard of
// shadow registers) and RO status words; IDLE/ACK/GAP single-beat protocol.
module opb_register_bank
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01003200,
  parameter logic [31:0] C_HIGHADDR   = 32'h010032FF,
  parameter int unsigned C_NUM_REGS   = 8,
  parameter int unsigned C_NUM_RO     = 4,
  parameter int unsigned C_SHADOW     = 1,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_load_strb,
  input  logic [32*C_NUM_RO-1:0]    user_data_in
);

  localparam int unsigned IDX_W = WORD_W - 2;
  localparam logic [IDX_W-1:0] CTRL_W = IDX_W'(C_NUM_REGS);

  opb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    widx_q, widx_d;
  logic [BYTES_W-1:0]  be_q, be_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                rnw_q, rnw_d;
  logic                ack_q, ack_d;
  logic [WORD_W-1:0]   dbus_q, dbus_d;

  logic [WORD_W-1:0]   addr, offset, rd_word;
  logic [IDX_W-1:0]    bus_w;
  logic                hit;
  logic                wr_en, ctrl_wr, commit, discard;
  logic [WORD_W-1:0]   rdback [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] pending;
  logic                unused_bits;

  assign addr   = opb_to_user32(OPB_ABus);
  assign offset = addr - C_BASEADDR;
  assign bus_w  = offset[WORD_W-1:2];
  assign hit    = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign unused_bits = ^{OPB_seqAddr, offset[1:0]};

  // Read mux on the live bus address; unmapped in-window offsets read zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < int'(C_NUM_REGS); i++)
      if (bus_w == IDX_W'(i)) rd_word = rdback[i];
    if (bus_w == CTRL_W && C_SHADOW != 0) rd_word = WORD_W'(pending);
    for (int j = 0; j < int'(C_NUM_RO); j++)
      if (bus_w == IDX_W'(C_NUM_REGS + 1 + j)) rd_word = user_data_in[32*j +: 32];
  end

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rnw_d   = rnw_q;
    ack_d   = 1'b0;
    dbus_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_ACK;
          widx_d  = bus_w;
          be_d    = opb_to_user_be(OPB_BE);
          wdata_d = opb_to_user32(OPB_DBus);
          rnw_d   = OPB_RNW;
          ack_d   = 1'b1;
          if (OPB_RNW) dbus_d = rd_word;
        end
      end
      ST_ACK:  state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q <= ST_IDLE;
      widx_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rnw_q   <= 1'b1;
      ack_q   <= 1'b0;
      dbus_q  <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rnw_q   <= rnw_d;
      ack_q   <= ack_d;
      dbus_q  <= dbus_d;
    end
  end

  // Writes land on the edge that closes the ACK cycle.
  assign wr_en   = (state_q == ST_ACK) && !rnw_q;
  assign ctrl_wr = wr_en && (widx_q == CTRL_W) && be_q[0];
  assign commit  = ctrl_wr && wdata_q[CTRL_COMMIT_BIT];
  assign discard = ctrl_wr && wdata_q[CTRL_DISCARD_BIT] && !wdata_q[CTRL_COMMIT_BIT];

  for (genvar g = 0; g < int'(C_NUM_REGS); g++) begin : g_slot
    opb_reg_slot #(.C_SHADOW(C_SHADOW)) u_slot (
      .clk       (OPB_Clk),
      .rst       (OPB_Rst),
      .wr_en_i   (wr_en && (widx_q == IDX_W'(g))),
      .be_i      (be_q),
      .wdata_i   (wdata_q),
      .commit_i  (commit),
      .discard_i (discard),
      .active_o  (user_data_out[32*g +: 32]),
      .rdback_o  (rdback[g]),
      .pending_o (pending[g]),
      .strb_o    (user_load_strb[g])
    );
  end

  assign Sl_DBus    = user_to_opb32(dbus_q);
  assign Sl_xferAck = ack_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule
